// File: rtl/nibble_serializador.sv
// nibble_serializador: feeds an operand pair to the serial comparator one bit pair per cycle, LSB first
module nibble_serializador #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ns_valid,
    input  logic [WIDTH-1:0] ns_a,
    input  logic [WIDTH-1:0] ns_b,
    output logic             ns_ready,
    output logic             ns_bit_a,
    output logic             ns_bit_b,
    output logic             ns_bit_valid,
    output logic             ns_first,
    output logic             ns_last,
    output logic             ns_done,
    output logic             ns_iguales
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sh_a, sh_b, sh_a_n, sh_b_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             eq, eq_n;
    logic             bit_a_n, bit_b_n, bit_valid_n, first_n, last_n, done_n, iguales_n;
    logic             accept;

    assign ns_ready = (state == IDLE) || ns_last;
    assign accept   = ns_valid && ns_ready;

    // state, shift registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sh_a         <= '0;
            sh_b         <= '0;
            cnt          <= '0;
            eq           <= 1'b0;
            ns_bit_a     <= 1'b0;
            ns_bit_b     <= 1'b0;
            ns_bit_valid <= 1'b0;
            ns_first     <= 1'b0;
            ns_last      <= 1'b0;
            ns_done      <= 1'b0;
            ns_iguales   <= 1'b0;
        end else begin
            state        <= state_n;
            sh_a         <= sh_a_n;
            sh_b         <= sh_b_n;
            cnt          <= cnt_n;
            eq           <= eq_n;
            ns_bit_a     <= bit_a_n;
            ns_bit_b     <= bit_b_n;
            ns_bit_valid <= bit_valid_n;
            ns_first     <= first_n;
            ns_last      <= last_n;
            ns_done      <= done_n;
            ns_iguales   <= iguales_n;
        end
    end

    // next state: shift out remaining bits, close the word with done, and load a new pair on accept
    always_comb begin
        state_n     = state;
        sh_a_n      = sh_a;
        sh_b_n      = sh_b;
        cnt_n       = cnt;
        eq_n        = eq;
        bit_a_n     = 1'b0;
        bit_b_n     = 1'b0;
        bit_valid_n = 1'b0;
        first_n     = 1'b0;
        last_n      = 1'b0;
        done_n      = 1'b0;
        iguales_n   = 1'b0;
        if (state == SHIFT && !ns_last) begin
            bit_a_n     = sh_a[0];
            bit_b_n     = sh_b[0];
            sh_a_n      = sh_a >> 1;
            sh_b_n      = sh_b >> 1;
            cnt_n       = cnt + 1'b1;
            bit_valid_n = 1'b1;
            last_n      = (cnt + 1'b1) == LAST;
        end
        if (state == SHIFT && ns_last) begin
            state_n   = IDLE;
            done_n    = 1'b1;
            iguales_n = eq;
        end
        if (accept) begin
            state_n     = SHIFT;
            bit_a_n     = ns_a[0];
            bit_b_n     = ns_b[0];
            sh_a_n      = ns_a >> 1;
            sh_b_n      = ns_b >> 1;
            cnt_n       = '0;
            eq_n        = ns_a == ns_b;
            bit_valid_n = 1'b1;
            first_n     = 1'b1;
            last_n      = 1'b0;
        end
    end
endmodule

// File: tb/tb_nibble_serializador.sv
// tb_nibble_serializador: directed and random stimulus against a per-cycle expected-output timeline
module tb_nibble_serializador;
    localparam int W = 4;
    localparam int N = 4200;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ns_valid = 1'b0;
    logic [W-1:0] ns_a = '0;
    logic [W-1:0] ns_b = '0;
    logic         ns_ready, ns_bit_a, ns_bit_b, ns_bit_valid, ns_first, ns_last, ns_done, ns_iguales;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic ea [N];
    logic eb [N];
    logic ev [N];
    logic ef [N];
    logic el [N];
    logic ed [N];
    logic ei [N];

    nibble_serializador #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .ns_valid(ns_valid), .ns_a(ns_a), .ns_b(ns_b),
        .ns_ready(ns_ready), .ns_bit_a(ns_bit_a), .ns_bit_b(ns_bit_b),
        .ns_bit_valid(ns_bit_valid), .ns_first(ns_first), .ns_last(ns_last),
        .ns_done(ns_done), .ns_iguales(ns_iguales)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    function automatic logic model_ready(input int c);
        return !ev[c] || el[c];
    endfunction

    // drive one edge: update the expected timeline, clock, then compare the following cycle
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
        int e;
        e = cyc + 1;
        reset    = r;
        ns_valid = v;
        ns_a     = a;
        ns_b     = b;
        if (r) begin
            for (int i = e; i <= e + W + 1 && i < N; i++) begin
                ea[i] = 0; eb[i] = 0; ev[i] = 0; ef[i] = 0; el[i] = 0; ed[i] = 0; ei[i] = 0;
            end
        end else if (v && model_ready(cyc)) begin
            for (int k = 0; k < W; k++) begin
                ea[e+k] = a[k];
                eb[e+k] = b[k];
                ev[e+k] = 1'b1;
                ef[e+k] = (k == 0);
                el[e+k] = (k == W - 1);
            end
            ed[e+W] = 1'b1;
            ei[e+W] = (a == b);
        end
        @(posedge clk);
        @(negedge clk);
        cyc = e;
        chk("ready", ns_ready, model_ready(cyc));
        chk("bit_a", ns_bit_a, ea[cyc]);
        chk("bit_b", ns_bit_b, eb[cyc]);
        chk("bit_valid", ns_bit_valid, ev[cyc]);
        chk("first", ns_first, ef[cyc]);
        chk("last", ns_last, el[cyc]);
        chk("done", ns_done, ed[cyc]);
        chk("iguales", ns_iguales, ei[cyc]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom), W'($urandom), 1'b0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ea[i] = 0; eb[i] = 0; ev[i] = 0; ef[i] = 0; el[i] = 0; ed[i] = 0; ei[i] = 0;
        end
        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        idle(2);
        step(1'b1, 4'b1010, 4'b0110, 1'b0);
        idle(6);
        step(1'b1, 4'h9, 4'h9, 1'b0);
        idle(6);
        step(1'b1, 4'h3, 4'hC, 1'b0);
        for (int i = 0; i < W; i++) step(1'b1, 4'hF, 4'h0, 1'b0);
        idle(6);
        step(1'b1, 4'h5, 4'hA, 1'b0);
        idle(2);
        step(1'b0, '0, '0, 1'b1);
        idle(6);
        step(1'b1, 4'h2, 4'h4, 1'b0);
        idle(1);
        step(1'b1, 4'hF, 4'hF, 1'b0);
        step(1'b1, 4'hF, 4'hF, 1'b0);
        idle(6);
        for (int i = 0; i < 2500; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            step($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 63) == 0);
        end
        idle(W + 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_serializador.md
# nibble_serializador

Upstream feeder for the serial nibble comparator. It accepts a pair of WIDTH-bit operands over a valid/ready handshake and presents them one bit pair per cycle, LSB first, on lines that drive the comparator's `bm_a`/`bm_b` inputs. Feeding LSB first makes the comparator's final selector value come from the most significant differing bit. A completion pulse is aligned with the cycle in which the comparator's outputs reflect the full word, together with an equality flag, because the comparator's selector holds a stale value when no bits differ.

## Interface
- `WIDTH`, 4, operand width in bits (≥ 2)
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state on a rising edge where it is high
- `ns_valid`  in  1  operand pair valid
- `ns_a`  in  WIDTH  operand A
- `ns_b`  in  WIDTH  operand B
- `ns_ready`  out  1  block accepts a pair on this edge when `ns_valid` is also high
- `ns_bit_a`  out  1  current bit of A, connects to comparator `bm_a`
- `ns_bit_b`  out  1  current bit of B, connects to comparator `bm_b`
- `ns_bit_valid`  out  1  a bit pair is being presented
- `ns_first`  out  1  presented pair is bit 0
- `ns_last`  out  1  presented pair is bit WIDTH-1
- `ns_done`  out  1  one-cycle pulse; comparator outputs are final this cycle
- `ns_iguales`  out  1  valid with `ns_done`: the accepted A equals the accepted B

## Operation
- Reset: state IDLE. `ns_bit_a`, `ns_bit_b`, `ns_bit_valid`, `ns_first`, `ns_last`, `ns_done`, and `ns_iguales` are 0. Shift registers and the bit counter are cleared.
- States: IDLE and SHIFT.
- `ns_ready` is combinational from registered state. It is 1 in IDLE, and 1 in SHIFT while `ns_last` is 1. It is 0 otherwise.
- Accept occurs on an edge where `ns_valid && ns_ready`. On accept:
  - load A and B into the shift registers
  - store the equality flag (A == B)
  - present bit 0: `ns_bit_valid`=1, `ns_first`=1, `ns_last`=0
  - set the counter to 0 and go to SHIFT
- SHIFT, not last bit: each edge presents the next bit (counter+1), with `ns_first`=0. `ns_last`=1 when the counter reaches WIDTH-1.
- SHIFT, last bit presented, no accept on this edge:
  - go to IDLE
  - `ns_bit_a`/`ns_bit_b`/`ns_bit_valid`/`ns_last` go to 0
  - `ns_done`=1 and `ns_iguales`=stored flag for one cycle
- SHIFT, last bit presented, accept on this edge:
  - the new pair's bit 0 is presented immediately
  - `ns_done`/`ns_iguales` still pulse for the old word on this edge
  - the equality flag is overwritten with the new pair's flag after it is issued to `ns_iguales`
- In IDLE, `ns_bit_a`/`ns_bit_b` are driven 0,0. The comparator then holds its selector and clears its "distintos" output.
- `ns_a`/`ns_b` are sampled only at accept and need not stay stable afterwards. `ns_valid` while `ns_ready`=0 is ignored and does not queue.
- `ns_iguales` is 0 in every cycle where `ns_done` is 0.
- Reset in mid-word: the word is dropped and no `ns_done` is issued. All outputs return to their reset values on the next edge. The comparator shares the same reset.

## Timing
- Accept on edge E0. Bit k is presented in the cycle after edge E0+k, for k = 0..WIDTH-1.
- The comparator registers the last bit on edge E0+WIDTH. `ns_done` is high in the cycle after E0+WIDTH, which is exactly when the comparator's selector and "distintos" outputs hold the final result.
- Sustained throughput is one pair per WIDTH cycles with zero gap when `ns_valid` is held high. Accept-to-done latency is WIDTH+1 edges.
- A back-to-back `ns_done` cycle coincides with the next word's bit 0. The comparator outputs are still the old word's result in that cycle.

## Test plan
- Reset: assert `reset` for 2 cycles → all outputs 0, `ns_ready`=1 in the first cycle after deassert, comparator selector=0.
- A=4'b1010, B=4'b0110 → bits (a,b) presented: (0,0), (1,1), (0,1), (1,0). `ns_first` is high on the first pair and `ns_last` on the fourth. `ns_done`=1 one cycle after the last bit, with `ns_iguales`=0 and comparator selector=0 (A larger).
- A=B=4'h9 → `ns_done` with `ns_iguales`=1. Comparator "distintos" is never 1 during the word.
- Back-to-back: `ns_valid` held high with pairs (4'h3,4'hC) then (4'hF,4'h0) → no idle gap; the second pair's bit 0 (1,0) appears in the first `ns_done` cycle. First done: `ns_iguales`=0, selector=1. Second done four cycles later: selector=0.
- Reset asserted during bit 2 of A=4'h5, B=4'hA → the next cycle has all outputs 0, `ns_ready`=1, and no `ns_done` ever pulses for that word.
- `ns_valid` pulsed with A=4'hF, B=4'hF during bits 1–2 of an in-flight word (A=4'h2, B=4'h4) → ignored. The stream and the `ns_done`/`ns_iguales`=0 result for 4'h2/4'h4 are unchanged, and no extra word follows.
